// File: rtl/alu_arbiter.sv
// alu_arbiter
// -----------------------------------------------------------------------------
// Shares one combinational ALU between two requesters. Each requester presents
// an operation on a valid/ready request channel. The granted operation is
// registered onto the ALU inputs, its result is captured one cycle later, and
// it is returned on that requester's valid/ready response channel.
// Arbitration is round-robin (FIXED_PRIO = 0) or req0-first (FIXED_PRIO = 1).
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   reqN_valid / reqN_ready  request handshake for requester N (N = 0, 1)
//   reqN_select, reqN_in_c   ALU opcode and carry/invert input for requester N
//   reqN_x, reqN_y           operands for requester N
//   rspN_valid / rspN_ready  response handshake for requester N
//   rspN_s, rspN_c           captured ALU result and carry-out
//   rspN_zero, rspN_ovf      captured ALU zero and overflow flags
//   alu_select, alu_in_c     registered drive to the shared ALU
//   alu_in_x, alu_in_y       registered operands to the shared ALU
//   alu_out_s, alu_out_c     ALU result and carry-out
//   alu_zero, alu_overflow   ALU flags
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH      = 4,
    parameter int FIXED_PRIO = 0
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_select,
    input  logic             req0_in_c,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_select,
    input  logic             req1_in_c,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_s,
    output logic             rsp0_c,
    output logic             rsp0_zero,
    output logic             rsp0_ovf,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_s,
    output logic             rsp1_c,
    output logic             rsp1_zero,
    output logic             rsp1_ovf,

    output logic [2:0]       alu_select,
    output logic             alu_in_c,
    output logic [WIDTH-1:0] alu_in_x,
    output logic [WIDTH-1:0] alu_in_y,
    input  logic [WIDTH-1:0] alu_out_s,
    input  logic             alu_out_c,
    input  logic             alu_zero,
    input  logic             alu_overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic owner;     // requester whose operation is in flight
    logic rr_last;   // requester served most recently; the other wins a tie
    logic grant0;
    logic grant1;
    logic accept;
    logic rsp_fire;

    // Grants exist only in IDLE. Gating with rst keeps both ready low while
    // the block is being reset, so no handshake can appear to complete.
    always_comb begin : grant_logic
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave a latch behind.
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !rst) begin
            case ({req1_valid, req0_valid})
                2'b01:   grant0 = 1'b1;
                2'b10:   grant1 = 1'b1;
                2'b11: begin
                    if (FIXED_PRIO != 0 || rr_last) grant0 = 1'b1;
                    else                            grant1 = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // A grant is only ever given to a valid requester, so a grant is an accept.
    assign accept   = grant0 | grant1;
    // Only the owner's response-ready matters; the other channel is ignored.
    assign rsp_fire = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);

    always_comb begin : next_state_logic
        state_next = state;
        case (state)
            IDLE:    if (accept)   state_next = EXEC;
            EXEC:                  state_next = RESP;
            RESP:    if (rsp_fire) state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin : state_reg
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values that were present before the edge.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin : datapath_reg
        if (rst) begin
            owner      <= 1'b0;
            rr_last    <= 1'b1;
            alu_select <= 3'd0;
            alu_in_c   <= 1'b0;
            alu_in_x   <= '0;
            alu_in_y   <= '0;
            rsp0_valid <= 1'b0;
            rsp0_s     <= '0;
            rsp0_c     <= 1'b0;
            rsp0_zero  <= 1'b0;
            rsp0_ovf   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_s     <= '0;
            rsp1_c     <= 1'b0;
            rsp1_zero  <= 1'b0;
            rsp1_ovf   <= 1'b0;
        end else begin
            // Operands are latched only on acceptance and then held, so the
            // ALU inputs stay at the last operation between requests.
            if (accept) begin
                owner      <= grant1;
                alu_select <= grant1 ? req1_select : req0_select;
                alu_in_c   <= grant1 ? req1_in_c   : req0_in_c;
                alu_in_x   <= grant1 ? req1_x      : req0_x;
                alu_in_y   <= grant1 ? req1_y      : req0_y;
            end

            // The ALU has had a full cycle of stable inputs by the EXEC edge.
            if (state == EXEC) begin
                if (owner) begin
                    rsp1_valid <= 1'b1;
                    rsp1_s     <= alu_out_s;
                    rsp1_c     <= alu_out_c;
                    rsp1_zero  <= alu_zero;
                    rsp1_ovf   <= alu_overflow;
                end else begin
                    rsp0_valid <= 1'b1;
                    rsp0_s     <= alu_out_s;
                    rsp0_c     <= alu_out_c;
                    rsp0_zero  <= alu_zero;
                    rsp0_ovf   <= alu_overflow;
                end
            end

            if (rsp_fire) begin
                rr_last <= owner;
                if (owner) rsp1_valid <= 1'b0;
                else       rsp0_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// -----------------------------------------------------------------------------
// Directed bench for alu_arbiter. Two instances share all request/response
// inputs: "dut" in round-robin mode and "dut_fp" in fixed-priority mode. Each
// instance drives its own copy of a small behavioural 4-bit ALU.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst;

    logic             req0_valid, req1_valid;
    logic [2:0]       req0_select, req1_select;
    logic             req0_in_c, req1_in_c;
    logic [WIDTH-1:0] req0_x, req0_y, req1_x, req1_y;
    logic             rsp0_ready, rsp1_ready;

    // round-robin instance outputs
    logic             req0_ready, req1_ready;
    logic             rsp0_valid, rsp0_c, rsp0_zero, rsp0_ovf;
    logic             rsp1_valid, rsp1_c, rsp1_zero, rsp1_ovf;
    logic [WIDTH-1:0] rsp0_s, rsp1_s;
    logic [2:0]       alu_select;
    logic             alu_in_c;
    logic [WIDTH-1:0] alu_in_x, alu_in_y, alu_out_s;
    logic             alu_out_c, alu_zero, alu_overflow;

    // fixed-priority instance outputs
    logic             f_req0_ready, f_req1_ready;
    logic             f_rsp0_valid, f_rsp0_c, f_rsp0_zero, f_rsp0_ovf;
    logic             f_rsp1_valid, f_rsp1_c, f_rsp1_zero, f_rsp1_ovf;
    logic [WIDTH-1:0] f_rsp0_s, f_rsp1_s;
    logic [2:0]       f_alu_select;
    logic             f_alu_in_c;
    logic [WIDTH-1:0] f_alu_in_x, f_alu_in_y, f_alu_out_s;
    logic             f_alu_out_c, f_alu_zero, f_alu_overflow;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Behavioural ALU: returns {s, carry, zero, overflow}.
    function automatic logic [WIDTH+2:0] alu_model(input logic [2:0] sel,
                                                   input logic ci,
                                                   input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y);
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] s, yy;
        logic             co, ov;
        s  = '0;
        co = 1'b0;
        ov = 1'b0;
        yy = y;
        case (sel)
            3'd0, 3'd1: begin
                yy  = (sel == 3'd1) ? ~y : y;
                sum = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, ci};
                s   = sum[WIDTH-1:0];
                co  = sum[WIDTH];
                ov  = (x[WIDTH-1] == yy[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
            end
            3'd2: s = x & y;
            3'd3: s = x | y;
            3'd4: s = x ^ y;
            3'd5: s = ~x;
            3'd6: begin s = {x[WIDTH-2:0], 1'b0}; co = x[WIDTH-1]; end
            default: begin s = {1'b0, x[WIDTH-1:1]}; co = x[0]; end
        endcase
        return {s, co, (s == '0), ov};
    endfunction

    assign {alu_out_s, alu_out_c, alu_zero, alu_overflow} =
        alu_model(alu_select, alu_in_c, alu_in_x, alu_in_y);
    assign {f_alu_out_s, f_alu_out_c, f_alu_zero, f_alu_overflow} =
        alu_model(f_alu_select, f_alu_in_c, f_alu_in_x, f_alu_in_y);

    alu_arbiter #(.WIDTH(WIDTH), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_select(req0_select),
        .req0_in_c(req0_in_c), .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_select(req1_select),
        .req1_in_c(req1_in_c), .req1_x(req1_x), .req1_y(req1_y),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_s(rsp0_s),
        .rsp0_c(rsp0_c), .rsp0_zero(rsp0_zero), .rsp0_ovf(rsp0_ovf),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_s(rsp1_s),
        .rsp1_c(rsp1_c), .rsp1_zero(rsp1_zero), .rsp1_ovf(rsp1_ovf),
        .alu_select(alu_select), .alu_in_c(alu_in_c), .alu_in_x(alu_in_x),
        .alu_in_y(alu_in_y), .alu_out_s(alu_out_s), .alu_out_c(alu_out_c),
        .alu_zero(alu_zero), .alu_overflow(alu_overflow)
    );

    alu_arbiter #(.WIDTH(WIDTH), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_select(req0_select),
        .req0_in_c(req0_in_c), .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_select(req1_select),
        .req1_in_c(req1_in_c), .req1_x(req1_x), .req1_y(req1_y),
        .rsp0_valid(f_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_s(f_rsp0_s),
        .rsp0_c(f_rsp0_c), .rsp0_zero(f_rsp0_zero), .rsp0_ovf(f_rsp0_ovf),
        .rsp1_valid(f_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_s(f_rsp1_s),
        .rsp1_c(f_rsp1_c), .rsp1_zero(f_rsp1_zero), .rsp1_ovf(f_rsp1_ovf),
        .alu_select(f_alu_select), .alu_in_c(f_alu_in_c), .alu_in_x(f_alu_in_x),
        .alu_in_y(f_alu_in_y), .alu_out_s(f_alu_out_s), .alu_out_c(f_alu_out_c),
        .alu_zero(f_alu_zero), .alu_overflow(f_alu_overflow)
    );

    // Inputs are driven and outputs sampled around the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1;
        @(negedge clk);
        #1;
        total++; if (req0_ready !== 1'b0) $display("FAIL reset_ready_gated: got %b want 0", req0_ready); else passed++;
        total++; if (rsp0_valid !== 1'b0) $display("FAIL reset_rsp0_valid: got %b want 0", rsp0_valid); else passed++;
        total++; if (rsp1_valid !== 1'b0) $display("FAIL reset_rsp1_valid: got %b want 0", rsp1_valid); else passed++;
        total++; if (alu_in_x !== 4'd0) $display("FAIL reset_alu_x: got %h want 0", alu_in_x); else passed++;
        total++; if (rsp0_s !== 4'd0) $display("FAIL reset_rsp0_s: got %h want 0", rsp0_s); else passed++;
        req0_valid = 1'b0;
        rst = 1'b0;
        tick();
        total++; if (req0_ready !== 1'b0) $display("FAIL reset_idle_ready: got %b want 0", req0_ready); else passed++;
    endtask

    task automatic test_single_add();
        req0_valid = 1'b1; req0_select = 3'd0; req0_in_c = 1'b0; req0_x = 4'd3; req0_y = 4'd4;
        #1;
        total++; if (req0_ready !== 1'b1) $display("FAIL add_req0_ready: got %b want 1", req0_ready); else passed++;
        total++; if (req1_ready !== 1'b0) $display("FAIL add_req1_ready: got %b want 0", req1_ready); else passed++;
        tick();
        req0_valid = 1'b0;
        #1;
        total++; if (req0_ready !== 1'b0) $display("FAIL add_exec_ready: got %b want 0", req0_ready); else passed++;
        total++; if (rsp0_valid !== 1'b0) $display("FAIL add_early_valid: got %b want 0", rsp0_valid); else passed++;
        total++; if ({alu_in_x, alu_in_y} !== 8'h34) $display("FAIL add_alu_ops: got %h want 34", {alu_in_x, alu_in_y}); else passed++;
        tick();
        total++; if (rsp0_valid !== 1'b1) $display("FAIL add_rsp_valid: got %b want 1", rsp0_valid); else passed++;
        total++; if (rsp0_s !== 4'd7) $display("FAIL add_s: got %0d want 7", rsp0_s); else passed++;
        total++; if ({rsp0_c, rsp0_zero, rsp0_ovf} !== 3'b000) $display("FAIL add_flags: got %b want 000", {rsp0_c, rsp0_zero, rsp0_ovf}); else passed++;
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        total++; if (rsp0_valid !== 1'b0) $display("FAIL add_rsp_clear: got %b want 0", rsp0_valid); else passed++;
    endtask

    task automatic test_sub_zero();
        req1_valid = 1'b1; req1_select = 3'd1; req1_in_c = 1'b1; req1_x = 4'd5; req1_y = 4'd5;
        #1;
        total++; if (req1_ready !== 1'b1) $display("FAIL sub_req1_ready: got %b want 1", req1_ready); else passed++;
        tick();
        req1_valid = 1'b0;
        total++; if (rsp0_valid !== 1'b0) $display("FAIL sub_rsp0_quiet_exec: got %b want 0", rsp0_valid); else passed++;
        tick();
        total++; if (rsp1_valid !== 1'b1) $display("FAIL sub_rsp1_valid: got %b want 1", rsp1_valid); else passed++;
        total++; if (rsp1_s !== 4'd0) $display("FAIL sub_s: got %0d want 0", rsp1_s); else passed++;
        total++; if ({rsp1_c, rsp1_zero, rsp1_ovf} !== 3'b110) $display("FAIL sub_flags: got %b want 110", {rsp1_c, rsp1_zero, rsp1_ovf}); else passed++;
        total++; if (rsp0_valid !== 1'b0) $display("FAIL sub_rsp0_quiet_resp: got %b want 0", rsp0_valid); else passed++;
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        total++; if (rsp1_valid !== 1'b0) $display("FAIL sub_rsp_clear: got %b want 0", rsp1_valid); else passed++;
    endtask

    // Both requesters held valid with responses always taken: one grant every
    // three cycles, alternating 0,1,0,1 in round-robin, always 0 when fixed.
    task automatic test_round_robin();
        apply_reset();
        req0_valid = 1'b1; req0_select = 3'd0; req0_in_c = 1'b0; req0_x = 4'd1; req0_y = 4'd1;
        req1_valid = 1'b1; req1_select = 3'd3; req1_in_c = 1'b0; req1_x = 4'd8; req1_y = 4'd1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if ({req1_ready, req0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10))
                $display("FAIL rr_grant%0d: got %b want %b", i, {req1_ready, req0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
            else passed++;
            total++; if ({f_req1_ready, f_req0_ready} !== 2'b01)
                $display("FAIL fp_grant%0d: got %b want 01", i, {f_req1_ready, f_req0_ready});
            else passed++;
            tick();
            total++; if ({req1_ready, req0_ready} !== 2'b00) $display("FAIL rr_exec_ready%0d: got %b want 00", i, {req1_ready, req0_ready}); else passed++;
            tick();
            total++; if ({rsp1_valid, rsp0_valid} !== ((i % 2 == 0) ? 2'b01 : 2'b10))
                $display("FAIL rr_rsp%0d: got %b want %b", i, {rsp1_valid, rsp0_valid}, (i % 2 == 0) ? 2'b01 : 2'b10);
            else passed++;
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    // Response held back for five cycles; a ready on the other channel and a
    // waiting req1 must both be ignored until rsp0 is taken.
    task automatic test_backpressure();
        req0_valid = 1'b1; req0_select = 3'd0; req0_in_c = 1'b0; req0_x = 4'd7; req0_y = 4'd1;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        rsp1_ready = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (rsp0_valid !== 1'b1) $display("FAIL bp_valid%0d: got %b want 1", i, rsp0_valid); else passed++;
            total++; if ({rsp0_s, rsp0_c, rsp0_ovf} !== 6'b1000_0_1) $display("FAIL bp_data%0d: got %b want 100001", i, {rsp0_s, rsp0_c, rsp0_ovf}); else passed++;
            total++; if (req1_ready !== 1'b0) $display("FAIL bp_no_grant%0d: got %b want 0", i, req1_ready); else passed++;
            tick();
        end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        #1;
        total++; if (rsp0_valid !== 1'b0) $display("FAIL bp_clear: got %b want 0", rsp0_valid); else passed++;
        total++; if (req1_ready !== 1'b1) $display("FAIL bp_idle_grant: got %b want 1", req1_ready); else passed++;
        req1_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset_mid_exec();
        req1_valid = 1'b1; req1_select = 3'd0; req1_in_c = 1'b0; req1_x = 4'd2; req1_y = 4'd3;
        tick();
        req1_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++; if (rsp1_valid !== 1'b0) $display("FAIL rst_rsp1_valid: got %b want 0", rsp1_valid); else passed++;
        total++; if ({alu_select, alu_in_c, alu_in_x, alu_in_y} !== 12'h000) $display("FAIL rst_alu_regs: got %h want 000", {alu_select, alu_in_c, alu_in_x, alu_in_y}); else passed++;
        total++; if ({rsp0_s, rsp0_c, rsp0_zero, rsp0_ovf} !== 7'd0) $display("FAIL rst_rsp0_data: got %b want 0", {rsp0_s, rsp0_c, rsp0_zero, rsp0_ovf}); else passed++;
        total++; if ({rsp1_s, rsp1_c, rsp1_zero, rsp1_ovf} !== 7'd0) $display("FAIL rst_rsp1_data: got %b want 0", {rsp1_s, rsp1_c, rsp1_zero, rsp1_ovf}); else passed++;
        tick();
        tick();
        total++; if (rsp1_valid !== 1'b0) $display("FAIL rst_no_late_rsp: got %b want 0", rsp1_valid); else passed++;
        req1_valid = 1'b1; req1_select = 3'd4; req1_in_c = 1'b0; req1_x = 4'hA; req1_y = 4'h6;
        #1;
        total++; if (req1_ready !== 1'b1) $display("FAIL rst_fresh_ready: got %b want 1", req1_ready); else passed++;
        tick();
        req1_valid = 1'b0;
        tick();
        total++; if ({rsp1_valid, rsp1_s, rsp1_zero} !== 6'b1_1100_0) $display("FAIL rst_fresh_rsp: got %b want 111000", {rsp1_valid, rsp1_s, rsp1_zero}); else passed++;
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
    endtask

    // req0 raises valid with new operands while req1 is in flight, then drops
    // it before the block is back in IDLE: nothing of req0's may execute.
    task automatic test_withdraw();
        apply_reset();
        req1_valid = 1'b1; req1_select = 3'd0; req1_in_c = 1'b0; req1_x = 4'd1; req1_y = 4'd1;
        #1;
        total++; if (req1_ready !== 1'b1) $display("FAIL wd_req1_ready: got %b want 1", req1_ready); else passed++;
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_select = 3'd5; req0_in_c = 1'b0; req0_x = 4'hF; req0_y = 4'hF;
        #1;
        total++; if (req0_ready !== 1'b0) $display("FAIL wd_exec_ready: got %b want 0", req0_ready); else passed++;
        tick();
        total++; if ({rsp1_valid, rsp1_s} !== 5'b1_0010) $display("FAIL wd_rsp1: got %b want 10010", {rsp1_valid, rsp1_s}); else passed++;
        req0_valid = 1'b0;
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        #1;
        total++; if (req0_ready !== 1'b0) $display("FAIL wd_idle_ready: got %b want 0", req0_ready); else passed++;
        tick();
        tick();
        total++; if (rsp0_valid !== 1'b0) $display("FAIL wd_no_rsp0: got %b want 0", rsp0_valid); else passed++;
        total++; if (alu_in_x !== 4'd1) $display("FAIL wd_alu_hold: got %h want 1", alu_in_x); else passed++;
    endtask

    // All eight opcodes pass through with x=6, y=3, in_c=0.
    task automatic test_opcodes();
        logic [3:0] exp_s [8];
        exp_s = '{4'd9, 4'd2, 4'd2, 4'd7, 4'd5, 4'd9, 4'd12, 4'd3};
        rsp0_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req0_valid = 1'b1; req0_select = 3'(i); req0_in_c = 1'b0; req0_x = 4'd6; req0_y = 4'd3;
            tick();
            req0_valid = 1'b0;
            total++; if (alu_select !== 3'(i)) $display("FAIL op%0d_select: got %0d want %0d", i, alu_select, i); else passed++;
            tick();
            total++; if (rsp0_s !== exp_s[i]) $display("FAIL op%0d_s: got %0d want %0d", i, rsp0_s, exp_s[i]); else passed++;
            tick();
        end
        rsp0_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_select = 3'd0; req0_in_c = 1'b0; req0_x = '0; req0_y = '0;
        req1_valid = 1'b0; req1_select = 3'd0; req1_in_c = 1'b0; req1_x = '0; req1_y = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        test_reset();
        test_single_add();
        test_sub_zero();
        test_round_robin();
        test_backpressure();
        test_reset_mid_exec();
        test_withdraw();
        test_opcodes();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
